// File: rtl/sf3_seq_pkg.sv
// Shared types, sizes and the test-pattern function for the SF3 erase/program/read sequencer.
package sf3_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERASE_CMD,
        S_ERASE_WAIT,
        S_PROG_CMD,
        S_PROG_DATA,
        S_PROG_WAIT,
        S_READ_CMD,
        S_READ_DATA,
        S_READ_WAIT,
        S_DONE
    } t_sf3_seq_state;

    localparam int unsigned c_page_bytes      = 256;
    localparam int unsigned c_subsector_bytes = 4096;
    localparam int unsigned c_page_bits       = $clog2(c_page_bytes);
    localparam int unsigned c_subsector_bits  = $clog2(c_subsector_bytes);
    localparam logic [8:0]  c_read_len        = 9'(c_page_bytes);

    // Deterministic pattern byte: seed + page + index, wrapping at 8 bits.
    function automatic logic [7:0] f_expected_byte(
        input logic [7:0] seed,
        input logic [7:0] page,
        input logic [7:0] idx
    );
        return seed + page + idx;
    endfunction

endpackage

// File: rtl/sf3_seq_read_checker.sv
// Read-back checker: compares each accepted byte with its expected value, keeps a
// saturating mismatch count and latches the flash address of the first mismatch.
module sf3_seq_read_checker
    import sf3_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        clear,
    input  logic        check_en,
    input  logic [7:0]  rd_data,
    input  logic [7:0]  exp_data,
    input  logic [31:0] rd_addr,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr
);

    logic mismatch;

    assign mismatch = check_en && (rd_data != exp_data);

    // Count mismatches (saturating) and capture the address of the first one of the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (ce) begin
            if (clear) begin
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (mismatch) begin
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
                if (err_count == '0) begin
                    first_err_addr <= rd_addr;
                end
            end
        end
    end

endmodule

// File: rtl/sf3_erase_prog_read_sequencer.sv
// Command sequencer for the PMOD SF3 driver: erases one 4 KiB subsector, programs it
// page by page with a seeded pattern, reads every page back and reports the outcome.
module sf3_erase_prog_read_sequencer
    import sf3_seq_pkg::*;
#(
    parameter int unsigned parm_pages       = 16,
    parameter logic [7:0]  parm_seed        = 8'h5A,
    parameter int unsigned parm_timeout_cyc = 2**24 - 1
)(
    input  logic        i_clk_mhz,
    input  logic        i_rst_mhz,
    input  logic        i_ce_mhz_div,
    input  logic        i_start,
    input  logic [31:0] i_base_addr,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic        o_timeout,
    output logic [15:0] o_err_count,
    output logic [31:0] o_first_err_addr,
    input  logic        i_command_ready,
    output logic [31:0] o_address_of_cmd,
    output logic        o_cmd_erase_subsector,
    output logic        o_cmd_page_program,
    output logic        o_cmd_random_read,
    output logic [8:0]  o_len_random_read,
    output logic [7:0]  o_wr_data_stream,
    output logic        o_wr_data_valid,
    input  logic        i_wr_data_ready,
    input  logic [7:0]  i_rd_data_stream,
    input  logic        i_rd_data_valid
);

    localparam logic [3:0] c_last_page = 4'(parm_pages - 1);
    localparam logic [7:0] c_last_byte = 8'(c_page_bytes - 1);

    t_sf3_seq_state state, state_next;

    logic [31:c_subsector_bits] base_q;
    logic [3:0]  page;
    logic [7:0]  byte_idx;
    logic [31:0] tmo_cnt;
    logic        seen_low;
    logic        timeout_q;
    logic        pass_q;
    logic        cmd_erase_q, cmd_prog_q, cmd_read_q;
    logic [31:0] cmd_addr_q;

    logic        start_acc, issue_cmd, page_step, in_timed, tmo_hit;
    logic        wr_xfer, rd_xfer;
    logic [7:0]  exp_byte;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic        unused_base_bits;

    assign unused_base_bits = ^i_base_addr[c_subsector_bits-1:0];

    assign wr_xfer  = (state == S_PROG_DATA) && i_wr_data_ready;
    assign rd_xfer  = (state == S_READ_DATA) && i_rd_data_valid;
    assign exp_byte = f_expected_byte(parm_seed, {4'h0, page}, byte_idx);

    // State register; the sequencer only moves on clock-enable cycles.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
            state <= S_IDLE;
        end else if (i_ce_mhz_div) begin
            state <= state_next;
        end
    end

    // Next-state decode plus the per-cycle strobes the datapath acts on.
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        start_acc  = 1'b0;
        issue_cmd  = 1'b0;
        page_step  = 1'b0;
        in_timed   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    start_acc  = 1'b1;
                    state_next = S_ERASE_CMD;
                end
            end
            S_ERASE_CMD, S_PROG_CMD, S_READ_CMD: begin
                if (i_command_ready) begin
                    issue_cmd = 1'b1;
                    case (state)
                        S_ERASE_CMD: state_next = S_ERASE_WAIT;
                        S_PROG_CMD:  state_next = S_PROG_DATA;
                        default:     state_next = S_READ_DATA;
                    endcase
                end
            end
            S_ERASE_WAIT, S_PROG_WAIT, S_READ_WAIT: begin
                in_timed = 1'b1;
                tmo_hit  = (tmo_cnt >= parm_timeout_cyc);
                if (tmo_hit) begin
                    state_next = S_DONE;
                end else if (seen_low && i_command_ready) begin
                    if (state == S_ERASE_WAIT) begin
                        state_next = S_PROG_CMD;
                    end else begin
                        page_step = 1'b1;
                        if (state == S_PROG_WAIT) begin
                            state_next = (page == c_last_page) ? S_READ_CMD : S_PROG_CMD;
                        end else begin
                            state_next = (page == c_last_page) ? S_DONE : S_READ_CMD;
                        end
                    end
                end
            end
            S_PROG_DATA, S_READ_DATA: begin
                in_timed = 1'b1;
                tmo_hit  = (tmo_cnt >= parm_timeout_cyc);
                if (tmo_hit) begin
                    state_next = S_DONE;
                end else if ((wr_xfer || rd_xfer) && (byte_idx == c_last_byte)) begin
                    state_next = (state == S_PROG_DATA) ? S_PROG_WAIT : S_READ_WAIT;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: page/byte counters, wait handshake tracking, timeout and command pulses.
    always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
            base_q      <= '0;
            page        <= '0;
            byte_idx    <= '0;
            tmo_cnt     <= '0;
            seen_low    <= 1'b0;
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            cmd_erase_q <= 1'b0;
            cmd_prog_q  <= 1'b0;
            cmd_read_q  <= 1'b0;
            cmd_addr_q  <= '0;
        end else if (i_ce_mhz_div) begin
            cmd_erase_q <= 1'b0;
            cmd_prog_q  <= 1'b0;
            cmd_read_q  <= 1'b0;
            if (start_acc) begin
                base_q    <= i_base_addr[31:c_subsector_bits];
                page      <= '0;
                byte_idx  <= '0;
                timeout_q <= 1'b0;
                pass_q    <= 1'b0;
            end
            if (issue_cmd) begin
                cmd_addr_q  <= {base_q, page, 8'h00};
                cmd_erase_q <= (state == S_ERASE_CMD);
                cmd_prog_q  <= (state == S_PROG_CMD);
                cmd_read_q  <= (state == S_READ_CMD);
                tmo_cnt     <= '0;
                seen_low    <= 1'b0;
                byte_idx    <= '0;
            end
            if (in_timed) begin
                tmo_cnt <= tmo_cnt + 32'd1;
                if (!i_command_ready) begin
                    seen_low <= 1'b1;
                end
            end
            if (wr_xfer || rd_xfer) begin
                byte_idx <= byte_idx + 8'd1;
            end
            if (page_step) begin
                page <= (page == c_last_page) ? 4'h0 : page + 4'd1;
            end
            if (tmo_hit) begin
                timeout_q <= 1'b1;
            end
            if ((state_next == S_DONE) && (state != S_DONE)) begin
                pass_q <= (err_count == '0) && !tmo_hit;
            end
        end
    end

    sf3_seq_read_checker u_checker (
        .clk            (i_clk_mhz),
        .rst            (i_rst_mhz),
        .ce             (i_ce_mhz_div),
        .clear          (start_acc),
        .check_en       (rd_xfer),
        .rd_data        (i_rd_data_stream),
        .exp_data       (exp_byte),
        .rd_addr        ({base_q, page, byte_idx}),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    assign o_busy                = (state != S_IDLE) && (state != S_DONE);
    assign o_done                = (state == S_DONE);
    assign o_pass                = pass_q;
    assign o_timeout             = timeout_q;
    assign o_err_count           = err_count;
    assign o_first_err_addr      = first_err_addr;
    assign o_address_of_cmd      = cmd_addr_q;
    assign o_cmd_erase_subsector = cmd_erase_q;
    assign o_cmd_page_program    = cmd_prog_q;
    assign o_cmd_random_read     = cmd_read_q;
    assign o_len_random_read     = c_read_len;
    assign o_wr_data_valid       = (state == S_PROG_DATA);
    assign o_wr_data_stream      = (state == S_PROG_DATA) ? exp_byte : 8'h00;

endmodule

// File: tb/tb_sf3_erase_prog_read_sequencer.sv
// Directed bench for the SF3 sequencer with a behavioural flash-driver model.
module tb_sf3_erase_prog_read_sequencer;

    localparam int unsigned c_timeout = 3000;

    logic        clk, rst, ce, start;
    logic [31:0] base_addr;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_erase, cmd_prog, cmd_read;
    logic [8:0]  len_read;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;

    sf3_erase_prog_read_sequencer #(
        .parm_pages       (16),
        .parm_seed        (8'h5A),
        .parm_timeout_cyc (c_timeout)
    ) dut (
        .i_clk_mhz             (clk),
        .i_rst_mhz             (rst),
        .i_ce_mhz_div          (ce),
        .i_start               (start),
        .i_base_addr           (base_addr),
        .o_busy                (busy),
        .o_done                (done),
        .o_pass                (pass),
        .o_timeout             (timeout),
        .o_err_count           (err_count),
        .o_first_err_addr      (first_err_addr),
        .i_command_ready       (cmd_ready),
        .o_address_of_cmd      (cmd_addr),
        .o_cmd_erase_subsector (cmd_erase),
        .o_cmd_page_program    (cmd_prog),
        .o_cmd_random_read     (cmd_read),
        .o_len_random_read     (len_read),
        .o_wr_data_stream      (wr_data),
        .o_wr_data_valid       (wr_valid),
        .i_wr_data_ready       (wr_ready),
        .i_rd_data_stream      (rd_data),
        .i_rd_data_valid       (rd_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // ---------------- driver model (acts on falling edges) ----------------
    int          m_mode;      // 0 faithful, 1 corrupt two bytes, 2 all zeros
    bit          m_hang;      // never release command_ready after erase
    bit          m_stall;     // random write-ready stalls
    int          m_phase, m_cnt, m_byte;
    logic [11:0] m_off;
    int          n_erase_total, n_prog, n_read, n_wr_bytes, n_dup, n_unstable;
    logic [31:0] erase_addr;
    logic [31:0] prog_addr [16];
    logic [31:0] read_addr [16];
    logic [7:0]  mem [4096];
    logic [7:0]  held_data;
    bit          held_valid;

    function automatic logic [7:0] model_read_byte(input int idx);
        logic [7:0] v;
        v = mem[idx];
        if (m_mode == 2) v = 8'h00;
        else if (m_mode == 1 && (idx == 3*256 + 7 || idx == 9*256 + 0)) v = ~v;
        return v;
    endfunction

    task automatic prog_decide();
        bit r;
        if (m_byte == 256) begin
            wr_ready = 1'b0;
            if (wr_valid) n_dup++;
            m_phase = 4;
            m_cnt   = 4;
        end else begin
            r = m_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (wr_valid && held_valid && !wr_ready && (wr_data !== held_data)) n_unstable++;
            held_data  = wr_data;
            held_valid = wr_valid;
            wr_ready   = r;
            if (r && wr_valid) begin
                mem[int'(m_off) + m_byte] = wr_data;
                m_byte++;
                n_wr_bytes++;
            end
        end
    endtask

    task automatic read_emit();
        if (m_byte == 256) begin
            rd_valid = 1'b1;      // stray byte after the page; must be ignored
            rd_data  = 8'hA5;
            m_phase  = 4;
            m_cnt    = 4;
        end else if ($urandom_range(0, 7) != 0) begin
            rd_valid = 1'b1;
            rd_data  = model_read_byte(int'(m_off) + m_byte);
            m_byte++;
        end else begin
            rd_valid = 1'b0;
        end
    endtask

    task automatic model_step();
        if (rst) begin
            cmd_ready = 1'b1;
            wr_ready  = 1'b0;
            rd_valid  = 1'b0;
            rd_data   = 8'h00;
            m_phase   = 0;
            return;
        end
        case (m_phase)
            0: begin
                if (cmd_erase) begin
                    n_erase_total++;
                    erase_addr = cmd_addr;
                    n_prog = 0; n_read = 0; n_wr_bytes = 0; n_dup = 0; n_unstable = 0;
                    for (int i = 0; i < 4096; i++) mem[i] = 8'hFF;
                    cmd_ready = 1'b0;
                    m_phase   = m_hang ? 5 : 1;
                    m_cnt     = 5;
                end else if (cmd_prog) begin
                    if (n_prog < 16) prog_addr[n_prog] = cmd_addr;
                    n_prog++;
                    m_off      = cmd_addr[11:0];
                    m_byte     = 0;
                    held_valid = 1'b0;
                    cmd_ready  = 1'b0;
                    m_phase    = 2;
                    prog_decide();
                end else if (cmd_read) begin
                    if (n_read < 16) read_addr[n_read] = cmd_addr;
                    n_read++;
                    m_off     = cmd_addr[11:0];
                    m_byte    = 0;
                    cmd_ready = 1'b0;
                    m_phase   = 3;
                    read_emit();
                end
            end
            1, 4: begin
                rd_valid = 1'b0;
                if (wr_valid) n_dup++;
                m_cnt--;
                if (m_cnt == 0) begin
                    cmd_ready = 1'b1;
                    m_phase   = 0;
                end
            end
            2: prog_decide();
            3: read_emit();
            default: begin
                if (!m_hang) begin
                    cmd_ready = 1'b1;
                    m_phase   = 0;
                end
            end
        endcase
    endtask

    initial begin
        cmd_ready = 1'b1; wr_ready = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
        m_phase = 0; m_cnt = 0; m_byte = 0; m_off = '0;
        n_erase_total = 0; n_prog = 0; n_read = 0; n_wr_bytes = 0; n_dup = 0; n_unstable = 0;
        erase_addr = '0; held_data = '0; held_valid = 1'b0;
        forever begin
            @(negedge clk);
            model_step();
        end
    end

    // ---------------- helpers ----------------
    logic        r_pass, r_timeout, r_busy;
    logic [15:0] r_err;
    logic [31:0] r_first;

    function automatic int count_mem_bad();
        int bad = 0;
        for (int p = 0; p < 16; p++)
            for (int b = 0; b < 256; b++)
                if (mem[p*256 + b] !== 8'(8'h5A + p + b)) bad++;
        return bad;
    endfunction

    function automatic int count_addr_bad(input logic [31:0] base);
        int bad = 0;
        for (int p = 0; p < 16; p++) begin
            if (prog_addr[p] !== base + 32'(p * 256)) bad++;
            if (read_addr[p] !== base + 32'(p * 256)) bad++;
        end
        return bad;
    endfunction

    task automatic run_once(input string tag, input logic [31:0] base);
        bit seen;
        seen      = 1'b0;
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1'b1);
        for (int i = 0; i < 30000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, seen, 1'b1);
        r_pass = pass; r_timeout = timeout; r_busy = busy; r_err = err_count; r_first = first_err_addr;
        check({tag, "_busy_at_done"}, r_busy, 1'b0);
        @(negedge clk);
        check({tag, "_done_one_cycle"}, done, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        int e0;
        rst = 1'b0; ce = 1'b1; start = 1'b0; base_addr = '0;
        m_mode = 0; m_hang = 1'b0; m_stall = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pass", pass, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_err", err_count, 16'd0);
        check("rst_first", first_err_addr, 32'd0);
        check("rst_len", len_read, 9'd256);
        check("rst_valid", wr_valid, 1'b0);
        check("rst_wdata", wr_data, 8'h00);
        check("rst_addr", cmd_addr, 32'd0);
        check("rst_pulses", {cmd_erase, cmd_prog, cmd_read}, 3'b000);

        // Start while clock enable is low is ignored
        ce = 1'b0; start = 1'b1; base_addr = 32'h0001_2345;
        repeat (2) @(negedge clk);
        start = 1'b0; ce = 1'b1;
        @(negedge clk);
        check("ce0_start_ignored", busy, 1'b0);

        // 1: clean run
        run_once("t1", 32'h0001_2345);
        check("t1_erase_addr", erase_addr, 32'h0001_2000);
        check("t1_n_prog", n_prog, 16);
        check("t1_n_read", n_read, 16);
        check("t1_addr_bad", count_addr_bad(32'h0001_2000), 0);
        check("t1_wr_bytes", n_wr_bytes, 4096);
        check("t1_mem_bad", count_mem_bad(), 0);
        check("t1_pass", r_pass, 1'b1);
        check("t1_err", r_err, 16'd0);
        check("t1_first", r_first, 32'd0);
        check("t1_timeout", r_timeout, 1'b0);
        check("t1_pass_held", pass, 1'b1);

        // 2: two corrupted read bytes
        m_mode = 1;
        run_once("t2", 32'h0001_2000);
        check("t2_err", r_err, 16'd2);
        check("t2_first", r_first, 32'h0001_2307);
        check("t2_pass", r_pass, 1'b0);
        check("t2_timeout", r_timeout, 1'b0);

        // 3: random write-ready stalls
        m_mode = 0; m_stall = 1'b1;
        run_once("t3", 32'h0001_2345);
        check("t3_wr_bytes", n_wr_bytes, 4096);
        check("t3_mem_bad", count_mem_bad(), 0);
        check("t3_last_byte", mem[15*256 + 255], 8'h68);
        check("t3_dup", n_dup, 0);
        check("t3_unstable", n_unstable, 0);
        check("t3_pass", r_pass, 1'b1);

        // 4: driver never comes back after erase
        m_stall = 1'b0; m_hang = 1'b1;
        run_once("t4", 32'h0001_2345);
        check("t4_timeout", r_timeout, 1'b1);
        check("t4_pass", r_pass, 1'b0);
        repeat (20) @(negedge clk);
        check("t4_no_prog", n_prog, 0);
        check("t4_timeout_sticky", timeout, 1'b1);

        // Reset clears held results
        m_hang = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_clears_timeout", timeout, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 5: start re-pulsed mid-run, then reset during program data
        e0 = n_erase_total;
        base_addr = 32'h0001_2345; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            if (wr_valid) seen = 1'b1;
        end
        check("t5_reached_prog_data", seen, 1'b1);
        check("t5_restart_ignored", n_erase_total - e0, 1);
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", wr_valid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_pulses", {cmd_erase, cmd_prog, cmd_read}, 3'b000);
        check("t5_rst_err", err_count, 16'd0);
        check("t5_rst_addr", cmd_addr, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_once("t5", 32'h0001_2345);
        check("t5_pass", r_pass, 1'b1);
        check("t5_wr_bytes", n_wr_bytes, 4096);

        // 6: all-zero read data
        m_mode = 2;
        run_once("t6", 32'h0001_2345);
        check("t6_err", r_err, 16'd4080);
        check("t6_first", r_first, 32'h0001_2000);
        check("t6_pass", r_pass, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
